// File: rtl/dsp_pair_accum.sv
// dsp_pair_accum
//   Two-lane vector accumulator behind a packed int8 DSP stage. Each accepted
//   beat carries two signed 16-bit products (lane AB and lane DB). Beats are
//   summed per lane until a beat with in_last=1 closes the vector. The sums,
//   the beat count and the per-lane saturation flags are then written to a
//   one-deep result stage that the consumer drains.
//
//   Optional feature (compile-time macro DSP_PAIR_ACC_SAT_EN):
//     defined   -> running sums clamp at the signed ACC_W limits and a sticky
//                  per-lane sat flag is reported with the vector.
//     undefined -> running sums wrap in two's complement; sat_ab/sat_db stay 0.
//
//   Handshakes: a transfer happens on a rising clk edge when valid and ready
//   are both high. Once valid is raised its payload is held until the
//   transfer. in_ready = ~out_valid | out_ready, so a pending result stalls
//   input and a beat can enter in the same cycle the result leaves.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid/in_ready    input beat handshake
//     in_last              beat closes the current vector
//     prod_ab, prod_db     signed 16-bit products, one per lane
//     out_valid/out_ready  result handshake
//     acc_ab, acc_db       signed vector sums (ACC_W bits)
//     beat_cnt             beats in the reported vector (saturates at all-ones)
//     sat_ab, sat_db       lane saturated at least once in the reported vector
//     state_dbg            FSM state: 0 = IDLE, 1 = ACCUM
module dsp_pair_accum #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [15:0]      prod_ab,
  input  logic [15:0]      prod_db,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_ab,
  output logic [ACC_W-1:0] acc_db,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             sat_ab,
  output logic             sat_db,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Adds a sign-extended product to a running sum.
  // Returns {overflow_flag, new_sum}.
  function automatic logic [ACC_W:0] lane_add(input logic [ACC_W-1:0] base,
                                               input logic [15:0]      prod);
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] sum;
    logic             ovf;
`ifdef DSP_PAIR_ACC_SAT_EN
    // One guard bit: the result overflowed when the two top bits disagree;
    // the guard bit then gives the true sign and picks the clamp value.
    wide = {base[ACC_W-1], base} + {{(ACC_W+1-16){prod[15]}}, prod};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    if (ovf) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = wide[ACC_W-1:0];
    end
`else
    wide = '0;
    sum  = base + {{(ACC_W-16){prod[15]}}, prod};
    ovf  = 1'b0;
`endif
    return {ovf, sum};
  endfunction

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_ab_q, sum_ab_d;
  logic [ACC_W-1:0] sum_db_q, sum_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_sat_ab_q, run_sat_ab_d;
  logic             run_sat_db_q, run_sat_db_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] res_ab_q, res_ab_d;
  logic [ACC_W-1:0] res_db_q, res_db_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_sat_ab_q, res_sat_ab_d;
  logic             res_sat_db_q, res_sat_db_d;

  logic             accept;
  logic [ACC_W:0]   step_ab;
  logic [ACC_W:0]   step_db;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_ab_next;
  logic             sat_db_next;

  always_comb begin
    state_d      = state_q;
    sum_ab_d     = sum_ab_q;
    sum_db_d     = sum_db_q;
    cnt_d        = cnt_q;
    run_sat_ab_d = run_sat_ab_q;
    run_sat_db_d = run_sat_db_q;
    out_valid_d  = out_valid_q;
    res_ab_d     = res_ab_q;
    res_db_d     = res_db_q;
    res_cnt_d    = res_cnt_q;
    res_sat_ab_d = res_sat_ab_q;
    res_sat_db_d = res_sat_db_q;

    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready;

    // A beat arriving in IDLE starts from zero, so no clear cycle is needed
    // between vectors; a lone 16-bit product can never overflow ACC_W >= 17.
    if (state_q == ACCUM) begin
      step_ab     = lane_add(sum_ab_q, prod_ab);
      step_db     = lane_add(sum_db_q, prod_db);
      cnt_next    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      sat_ab_next = run_sat_ab_q | step_ab[ACC_W];
      sat_db_next = run_sat_db_q | step_db[ACC_W];
    end else begin
      step_ab     = lane_add('0, prod_ab);
      step_db     = lane_add('0, prod_db);
      cnt_next    = CNT_W'(1);
      sat_ab_next = step_ab[ACC_W];
      sat_db_next = step_db[ACC_W];
    end

    if (accept) begin
      sum_ab_d     = step_ab[ACC_W-1:0];
      sum_db_d     = step_db[ACC_W-1:0];
      cnt_d        = cnt_next;
      run_sat_ab_d = sat_ab_next;
      run_sat_db_d = sat_db_next;
      state_d      = in_last ? IDLE : ACCUM;
    end

    // A closing beat loads the result even while the previous one is being
    // taken in this cycle, keeping out_valid high back to back.
    if (accept && in_last) begin
      out_valid_d  = 1'b1;
      res_ab_d     = step_ab[ACC_W-1:0];
      res_db_d     = step_db[ACC_W-1:0];
      res_cnt_d    = cnt_next;
      res_sat_ab_d = sat_ab_next;
      res_sat_db_d = sat_db_next;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sum_ab_q     <= '0;
      sum_db_q     <= '0;
      cnt_q        <= '0;
      run_sat_ab_q <= 1'b0;
      run_sat_db_q <= 1'b0;
      out_valid_q  <= 1'b0;
      res_ab_q     <= '0;
      res_db_q     <= '0;
      res_cnt_q    <= '0;
      res_sat_ab_q <= 1'b0;
      res_sat_db_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_ab_q     <= sum_ab_d;
      sum_db_q     <= sum_db_d;
      cnt_q        <= cnt_d;
      run_sat_ab_q <= run_sat_ab_d;
      run_sat_db_q <= run_sat_db_d;
      out_valid_q  <= out_valid_d;
      res_ab_q     <= res_ab_d;
      res_db_q     <= res_db_d;
      res_cnt_q    <= res_cnt_d;
      res_sat_ab_q <= res_sat_ab_d;
      res_sat_db_q <= res_sat_db_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_ab    = res_ab_q;
  assign acc_db    = res_db_q;
  assign beat_cnt  = res_cnt_q;
  assign sat_ab    = res_sat_ab_q;
  assign sat_db    = res_sat_db_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dsp_pair_accum.sv
// Bench for dsp_pair_accum. Two instances share one input stream:
//   dut1: default widths (ACC_W=32, CNT_W=16)
//   dut2: narrow widths (ACC_W=17, CNT_W=2) so overflow and count saturation
//         occur often.
// A reference model keeps the beats of the open vector in queues and, when
// the closing beat is accepted, computes the expected result with plain
// integer arithmetic. It pushes that result onto an expected queue.
module tb_dsp_pair_accum;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] prod_ab = '0;
  logic [15:0] prod_db = '0;
  logic        out_ready = 1'b1;
  logic        rand_ready = 1'b0;

  logic        in_ready1, out_valid1, sat_ab1, sat_db1, state_dbg1;
  logic [31:0] acc_ab1, acc_db1;
  logic [15:0] beat_cnt1;
  logic        in_ready2, out_valid2, sat_ab2, sat_db2, state_dbg2;
  logic [16:0] acc_ab2, acc_db2;
  logic [1:0]  beat_cnt2;

  dsp_pair_accum dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .prod_ab(prod_ab), .prod_db(prod_db),
    .out_valid(out_valid1), .out_ready(out_ready), .acc_ab(acc_ab1),
    .acc_db(acc_db1), .beat_cnt(beat_cnt1), .sat_ab(sat_ab1),
    .sat_db(sat_db1), .state_dbg(state_dbg1)
  );

  dsp_pair_accum #(.ACC_W(17), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_last(in_last), .prod_ab(prod_ab), .prod_db(prod_db),
    .out_valid(out_valid2), .out_ready(out_ready), .acc_ab(acc_ab2),
    .acc_db(acc_db2), .beat_cnt(beat_cnt2), .sat_ab(sat_ab2),
    .sat_db(sat_db2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int ab_beats[$];
  int db_beats[$];
  // dut1 packing: {sat_ab, sat_db, cnt[15:0], acc_db[31:0], acc_ab[31:0]}
  logic [81:0] exp1_q[$];
  // dut2 packing: {sat_ab, sat_db, cnt[1:0], acc_db[16:0], acc_ab[16:0]}
  logic [37:0] exp2_q[$];

  // Sum one lane of a vector at width w: clamp with a sticky flag when
  // saturation is built in, otherwise wrap modulo 2^w.
  function automatic void model_lane(input int vals[$], input int w,
                                     output longint acc, output logic sat);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    longint m  = longint'(1) <<< w;
    acc = 0;
    sat = 1'b0;
    foreach (vals[i]) begin
      acc += vals[i];
`ifdef DSP_PAIR_ACC_SAT_EN
      if (acc > mx) begin acc = mx; sat = 1'b1; end
      else if (acc < mn) begin acc = mn; sat = 1'b1; end
`else
      acc = ((acc % m) + m) % m;
      if (acc > mx) acc -= m;
`endif
    end
  endfunction

  function automatic logic [81:0] make_exp1();
    longint a, d;
    logic   sa, sd;
    logic [15:0] c;
    model_lane(ab_beats, 32, a, sa);
    model_lane(db_beats, 32, d, sd);
    c = (ab_beats.size() > 65535) ? 16'hFFFF : 16'(ab_beats.size());
    return {sa, sd, c, d[31:0], a[31:0]};
  endfunction

  function automatic logic [37:0] make_exp2();
    longint a, d;
    logic   sa, sd;
    logic [1:0] c;
    model_lane(ab_beats, 17, a, sa);
    model_lane(db_beats, 17, d, sd);
    c = (ab_beats.size() > 3) ? 2'd3 : 2'(ab_beats.size());
    return {sa, sd, c, d[16:0], a[16:0]};
  endfunction

  // Monitor on the falling edge: compare the pending result against the
  // model, then apply this cycle's handshakes to the model.
  logic        ready_m;
  logic [81:0] e1;
  logic [37:0] e2;
  always @(negedge clk) begin
    if (rst_n) begin
      ready_m = (exp1_q.size() == 0) || out_ready;
      check("in_ready1", in_ready1, ready_m);
      check("in_ready2", in_ready2, ready_m);
      check("out_valid1", out_valid1, exp1_q.size() != 0);
      check("out_valid2", out_valid2, exp2_q.size() != 0);
      check("state1", state_dbg1, ab_beats.size() != 0);
      check("state2", state_dbg2, ab_beats.size() != 0);
      if (exp1_q.size() != 0) begin
        e1 = exp1_q[0];
        check("acc_ab1", acc_ab1, e1[31:0]);
        check("acc_db1", acc_db1, e1[63:32]);
        check("cnt1", beat_cnt1, e1[79:64]);
        check("sat_db1", sat_db1, e1[80]);
        check("sat_ab1", sat_ab1, e1[81]);
        if (out_ready) void'(exp1_q.pop_front());
      end
      if (exp2_q.size() != 0) begin
        e2 = exp2_q[0];
        check("acc_ab2", acc_ab2, e2[16:0]);
        check("acc_db2", acc_db2, e2[33:17]);
        check("cnt2", beat_cnt2, e2[35:34]);
        check("sat_db2", sat_db2, e2[36]);
        check("sat_ab2", sat_ab2, e2[37]);
        if (out_ready) void'(exp2_q.pop_front());
      end
      if (in_valid && ready_m) begin
        ab_beats.push_back(int'($signed(prod_ab)));
        db_beats.push_back(int'($signed(prod_db)));
        if (in_last) begin
          exp1_q.push_back(make_exp1());
          exp2_q.push_back(make_exp2());
          ab_beats.delete();
          db_beats.delete();
        end
      end
    end
  end

  // Random backpressure on the result side.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_beat(input logic [15:0] ab, input logic [15:0] db,
                           input logic last);
    int n = 0;
    in_valid = 1'b1;
    prod_ab  = ab;
    prod_db  = db;
    in_last  = last;
    @(negedge clk);
    while (!in_ready1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready1) check("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    // Idle-cycle garbage must be ignored.
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    prod_ab  = 16'($urandom);
    prod_db  = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ab_beats.delete();
    db_beats.delete();
    exp1_q.delete();
    exp2_q.delete();
    @(negedge clk);
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_acc_ab", acc_ab1, 32'd0);
    check("rst_acc_db", acc_db1, 32'd0);
    check("rst_cnt", beat_cnt1, 16'd0);
    check("rst_sat", {sat_ab1, sat_db1, sat_ab2, sat_db2}, 4'd0);
    check("rst_in_ready", in_ready1, 1'b1);
    check("rst_state", state_dbg1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(2);
    do_reset();

    // Three-beat vector.
    send_beat(16'd100, -16'sd1, 1'b0);
    send_beat(-16'sd50, 16'd2, 1'b0);
    send_beat(16'd7, 16'd3, 1'b1);
    @(negedge clk);
    check("v3_valid", out_valid1, 1'b1);
    check("v3_acc_ab", acc_ab1, 32'd57);
    check("v3_acc_db", acc_db1, 32'd4);
    check("v3_cnt", beat_cnt1, 16'd3);
    idle(1);

    // Single negative beat.
    send_beat(16'hC000, 16'd0, 1'b1);
    @(negedge clk);
    check("neg_acc_ab", acc_ab1, 32'hFFFFC000);
    check("neg_cnt", beat_cnt1, 16'd1);
    idle(1);

    // Overflow of the 17-bit lane.
    send_beat(16'd32767, 16'd0, 1'b0);
    send_beat(16'd32767, 16'd0, 1'b0);
    send_beat(16'd32767, 16'd0, 1'b1);
    @(negedge clk);
    check("ovf_acc_ab1", acc_ab1, 32'd98301);
`ifdef DSP_PAIR_ACC_SAT_EN
    check("ovf_acc_ab2", acc_ab2, 17'd65535);
    check("ovf_sat_ab2", sat_ab2, 1'b1);
`else
    check("ovf_acc_ab2", acc_ab2, 17'h17FFD);
    check("ovf_sat_ab2", sat_ab2, 1'b0);
`endif
    idle(1);

    // Stall with a pending result, then take it and a new closing beat in
    // the same cycle.
    out_ready = 1'b0;
    send_beat(16'd11, 16'd22, 1'b1);
    in_valid = 1'b1;
    prod_ab  = 16'd5;
    prod_db  = 16'd6;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready1, 1'b0);
      check("stall_acc_ab", acc_ab1, 32'd11);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("take_in_ready", in_ready1, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("b2b_valid", out_valid1, 1'b1);
    check("b2b_acc_ab", acc_ab1, 32'd5);
    check("b2b_cnt", beat_cnt1, 16'd1);
    idle(1);

    // Count saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) send_beat(16'd1, 16'd1, i == 4);
    @(negedge clk);
    check("cnt_sat2", beat_cnt2, 2'd3);
    check("cnt_sat1", beat_cnt1, 16'd5);
    idle(1);

    // Reset in the middle of a vector.
    send_beat(16'd1000, 16'd1000, 1'b0);
    send_beat(16'd1000, 16'd1000, 1'b0);
    do_reset();
    send_beat(16'd9, 16'd8, 1'b1);
    @(negedge clk);
    check("post_rst_acc_ab", acc_ab1, 32'd9);
    check("post_rst_cnt", beat_cnt1, 16'd1);
    idle(1);

    // Random vectors with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 300; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_beat(16'($urandom), 16'($urandom), b == len - 1);
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(4);
    check("drain1", exp1_q.size(), 0);
    check("drain2", exp2_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
